// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor table.
package bp_pkg;

  typedef enum logic [0:0] {
    BP_BIMODAL,
    BP_GSHARE
  } bp_mode_t;

  // Widest counter the helper functions handle.
  localparam int unsigned MaxCtrW = 16;

  // Weak-untaken init value for the common 2-bit counter.
  localparam logic [1:0] CtrWeakUntaken2 = 2'b01;

  // Weakly-untaken value for an arbitrary counter width: 2**(width-1)-1.
  function automatic logic [MaxCtrW-1:0] weak_untaken(int unsigned width);
    return (MaxCtrW'(1) << (width - 1)) - MaxCtrW'(1);
  endfunction

  // Saturating increment (taken) or decrement (untaken) of a width-bit counter.
  function automatic logic [MaxCtrW-1:0] sat_next(logic [MaxCtrW-1:0] ctr, logic taken,
                                                  int unsigned width);
    logic [MaxCtrW-1:0] max_val;
    max_val = {MaxCtrW{1'b1}} >> (MaxCtrW - width);
    if (taken) begin
      return (ctr == max_val) ? ctr : ctr + MaxCtrW'(1);
    end
    return (ctr == '0) ? ctr : ctr - MaxCtrW'(1);
  endfunction

endpackage

// File: rtl/branch_history_table_if.sv
// Fetch/execute signal bundle between the pipeline and the branch history table.
interface branch_history_table_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned IDX_W = 6
);
  logic [XLEN-1:0]  pc_f;           // fetch PC
  logic             pc_src_pred_f;  // predicted taken
  logic [IDX_W-1:0] pred_idx_f;     // index used for the prediction
  logic             update_en_e;    // resolved conditional branch in execute
  logic [IDX_W-1:0] update_idx_e;   // index carried down with that branch
  logic             pc_src_res_e;   // resolved outcome, 1 = taken
  logic [IDX_W-1:0] ghr;            // global history (observability)

  // Pipeline side.
  modport master (
    output pc_f, update_en_e, update_idx_e, pc_src_res_e,
    input  pc_src_pred_f, pred_idx_f, ghr
  );

  // Predictor side.
  modport slave (
    input  pc_f, update_en_e, update_idx_e, pc_src_res_e,
    output pc_src_pred_f, pred_idx_f, ghr
  );
endinterface

// File: rtl/sat_counter.sv
// One saturating predictor counter; next_o is the value it would take on an update.
module sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             taken_i,
  output logic [CTR_W-1:0] ctr_o,
  output logic [CTR_W-1:0] next_o
);

  localparam logic [CTR_W-1:0] InitVal = CTR_W'(weak_untaken(CTR_W));

  logic [CTR_W-1:0] ctr_q, ctr_d;

  // Saturated step in the resolved direction.
  always_comb begin
    next_o = CTR_W'(sat_next(MaxCtrW'(ctr_q), taken_i, CTR_W));
    ctr_d  = enable_i ? next_o : ctr_q;
  end

  // Counter state; reset wins over any concurrent update.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ctr_q <= InitVal;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign ctr_o = ctr_q;

endmodule

// File: rtl/branch_history_table.sv
// Table of saturating-counter branch predictors with bimodal or gshare indexing.
module branch_history_table
  import bp_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned CTR_W  = 2,
  parameter bp_mode_t    MODE   = BP_BIMODAL,
  parameter bit          BYPASS = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  branch_history_table_if.slave  bus
);

  localparam int unsigned NumEntries = 1 << IDX_W;

  logic [CTR_W-1:0] ctr  [NumEntries];
  logic [CTR_W-1:0] next [NumEntries];
  logic [IDX_W-1:0] ghr_q, ghr_d;
  logic [IDX_W-1:0] base_idx, rd_idx;
  logic [CTR_W-1:0] rd_ctr;
  logic             unused_pc;

  assign base_idx  = bus.pc_f[IDX_W+1:2];
  assign unused_pc = ^{bus.pc_f[XLEN-1:IDX_W+2], bus.pc_f[1:0]};

  for (genvar i = 0; i < int'(NumEntries); i++) begin : g_ctr
    sat_counter #(
      .CTR_W (CTR_W)
    ) u_ctr (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .enable_i (bus.update_en_e && (bus.update_idx_e == IDX_W'(i))),
      .taken_i  (bus.pc_src_res_e),
      .ctr_o    (ctr[i]),
      .next_o   (next[i])
    );
  end

  // History only advances on resolved branches; bimodal keeps it at zero.
  if (MODE == BP_GSHARE) begin : g_gshare
    logic [IDX_W-1:0] ghr_shift;
    if (IDX_W == 1) begin : g_one
      assign ghr_shift = bus.pc_src_res_e;
    end else begin : g_many
      assign ghr_shift = {ghr_q[IDX_W-2:0], bus.pc_src_res_e};
    end
    // Next history: shift in the resolved outcome.
    always_comb begin
      ghr_d = ghr_q;
      if (bus.update_en_e) ghr_d = ghr_shift;
    end
  end else begin : g_bimodal
    // Next history: always zero.
    always_comb begin
      ghr_d = '0;
    end
  end

  // Global history register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  // Fetch index uses the pre-update history; optional forwarding of a same-index update.
  always_comb begin
    rd_idx = (MODE == BP_GSHARE) ? (base_idx ^ ghr_q) : base_idx;
    rd_ctr = ctr[rd_idx];
    if (BYPASS && bus.update_en_e && (bus.update_idx_e == rd_idx)) begin
      rd_ctr = next[rd_idx];
    end
  end

  assign bus.pred_idx_f    = rd_idx;
  assign bus.pc_src_pred_f = rd_ctr[CTR_W-1];
  assign bus.ghr           = ghr_q;

endmodule

// File: tb/tb_branch_history_table.sv
// Directed bench: two bimodal tables (no bypass / bypass) share stimulus; a gshare table
// is driven separately.
module tb_branch_history_table;
  import bp_pkg::*;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  branch_history_table_if #(.XLEN(32), .IDX_W(6)) bus0 ();
  branch_history_table_if #(.XLEN(32), .IDX_W(6)) bus1 ();
  branch_history_table_if #(.XLEN(32), .IDX_W(4)) bus2 ();

  branch_history_table #(
    .XLEN(32), .IDX_W(6), .CTR_W(2), .MODE(BP_BIMODAL), .BYPASS(1'b0)
  ) u_dut0 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus0.slave)
  );

  branch_history_table #(
    .XLEN(32), .IDX_W(6), .CTR_W(2), .MODE(BP_BIMODAL), .BYPASS(1'b1)
  ) u_dut1 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus1.slave)
  );

  branch_history_table #(
    .XLEN(32), .IDX_W(4), .CTR_W(2), .MODE(BP_GSHARE), .BYPASS(1'b0)
  ) u_dut2 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus2.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic        en;
    logic [5:0]  idx;
    logic        res;
    logic        exp0;  // expected prediction, BYPASS=0
    logic        exp1;  // expected prediction, BYPASS=1
  } vec_t;

  localparam int NumVec = 16;
  vec_t vecs [NumVec];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_bim(input logic [31:0] pc, input logic en, input logic [5:0] idx,
                           input logic res);
    bus0.pc_f = pc; bus0.update_en_e = en; bus0.update_idx_e = idx; bus0.pc_src_res_e = res;
    bus1.pc_f = pc; bus1.update_en_e = en; bus1.update_idx_e = idx; bus1.pc_src_res_e = res;
  endtask

  task automatic drive_gs(input logic [31:0] pc, input logic en, input logic res);
    bus2.pc_f = pc; bus2.update_en_e = en; bus2.update_idx_e = 4'd0; bus2.pc_src_res_e = res;
  endtask

  initial begin
    // Counter histories: idx5 01->10->11->11->10 ; idx9 saturates at 00 ; idx3 bypass case.
    vecs[0]  = '{32'h14, 1'b1, 6'd5, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{32'h14, 1'b1, 6'd5, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{32'h14, 1'b1, 6'd5, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{32'h14, 1'b1, 6'd5, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{32'h14, 1'b0, 6'd5, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{32'h24, 1'b1, 6'd9, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'h24, 1'b1, 6'd9, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h24, 1'b1, 6'd9, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'h24, 1'b1, 6'd9, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h24, 1'b0, 6'd9, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h24, 1'b1, 6'd9, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{32'h24, 1'b0, 6'd9, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{32'h0c, 1'b1, 6'd3, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{32'h0c, 1'b0, 6'd3, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{32'h10, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{32'h14, 1'b0, 6'd5, 1'b0, 1'b0, 1'b0};

    reset_i = 1'b1;
    drive_bim(32'h0, 1'b0, 6'd0, 1'b0);
    drive_gs(32'h0, 1'b0, 1'b0);
    #12;
    chk("reset_pred0", {31'd0, bus0.pc_src_pred_f}, 32'd0);
    chk("reset_ghr2", {28'd0, bus2.ghr}, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;

    // Every entry predicts untaken out of reset.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_i);
      drive_bim(32'(i) << 2, 1'b0, 6'd0, 1'b0);
      #1;
      chk("sweep_pred0", {31'd0, bus0.pc_src_pred_f}, 32'd0);
      chk("sweep_idx0", {26'd0, bus0.pred_idx_f}, 32'(i));
    end
    chk("sweep_ghr0", {26'd0, bus0.ghr}, 32'd0);

    for (int v = 0; v < NumVec; v++) begin
      @(negedge clk_i);
      drive_bim(vecs[v].pc, vecs[v].en, vecs[v].idx, vecs[v].res);
      #1;
      chk($sformatf("vec%0d_pred_nobyp", v), {31'd0, bus0.pc_src_pred_f}, {31'd0, vecs[v].exp0});
      chk($sformatf("vec%0d_pred_byp", v), {31'd0, bus1.pc_src_pred_f}, {31'd0, vecs[v].exp1});
      chk($sformatf("vec%0d_idx", v), {26'd0, bus0.pred_idx_f}, {26'd0, vecs[v].pc[7:2]});
    end
    @(negedge clk_i);
    drive_bim(32'h0c, 1'b0, 6'd0, 1'b0);
    #1;
    chk("bimodal_ghr_held", {26'd0, bus0.ghr}, 32'd0);

    // Gshare: taken, taken, untaken on entry 0; index uses pre-update history.
    @(negedge clk_i);
    drive_gs(32'h40, 1'b1, 1'b1);
    #1;
    chk("gs_ghr_a", {28'd0, bus2.ghr}, 32'h0);
    chk("gs_idx_a", {28'd0, bus2.pred_idx_f}, 32'h0);
    @(negedge clk_i);
    drive_gs(32'h40, 1'b1, 1'b1);
    #1;
    chk("gs_ghr_b", {28'd0, bus2.ghr}, 32'h1);
    chk("gs_idx_b", {28'd0, bus2.pred_idx_f}, 32'h1);
    @(negedge clk_i);
    drive_gs(32'h40, 1'b1, 1'b0);
    #1;
    chk("gs_ghr_c", {28'd0, bus2.ghr}, 32'h3);
    chk("gs_idx_c", {28'd0, bus2.pred_idx_f}, 32'h3);
    @(negedge clk_i);
    drive_gs(32'h40, 1'b0, 1'b0);
    #1;
    chk("gs_ghr_final", {28'd0, bus2.ghr}, 32'h6);
    chk("gs_idx_final", {28'd0, bus2.pred_idx_f}, 32'h6);
    chk("gs_pred_idx6", {31'd0, bus2.pc_src_pred_f}, 32'd0);
    drive_gs(32'h18, 1'b0, 1'b0);
    #1;
    chk("gs_idx_alias0", {28'd0, bus2.pred_idx_f}, 32'h0);
    chk("gs_pred_idx0", {31'd0, bus2.pc_src_pred_f}, 32'd1);

    // Reset asserted between edges with an update pending, held across one posedge.
    @(negedge clk_i);
    drive_bim(32'h0c, 1'b1, 6'd3, 1'b1);
    drive_gs(32'h40, 1'b1, 1'b1);
    #1;
    chk("prerst_pred0", {31'd0, bus0.pc_src_pred_f}, 32'd1);
    reset_i = 1'b1;
    #1;
    chk("rst_pred0_now", {31'd0, bus0.pc_src_pred_f}, 32'd0);
    chk("rst_ghr2_now", {28'd0, bus2.ghr}, 32'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    drive_bim(32'h0c, 1'b0, 6'd3, 1'b0);
    drive_gs(32'h40, 1'b0, 1'b0);
    #1;
    chk("postrst_pred0", {31'd0, bus0.pc_src_pred_f}, 32'd0);
    chk("postrst_pred1", {31'd0, bus1.pc_src_pred_f}, 32'd0);
    chk("postrst_ghr2", {28'd0, bus2.ghr}, 32'd0);
    drive_bim(32'h14, 1'b0, 6'd0, 1'b0);
    #1;
    chk("postrst_idx5", {31'd0, bus0.pc_src_pred_f}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
